// File: rtl/regs_mp_if.sv
// regs_mp_if: bus bundle between the DPROC pipeline and the regs_mp register file.
//   master : decode/writeback side (drives addresses, reserve, write, flush)
//   slave  : register file side (drives read data, busy flags, busy count)
// Signals:
//   raddr_i        NB_READ_PORTS*ADDR_WIDTH  read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   rdata_o        NB_READ_PORTS*DATA_WIDTH  read data, same slicing
//   rbusy_o        NB_READ_PORTS             pending-write flag per read port
//   reserve_i      1                         mark reserve_addr_i pending at next edge
//   reserve_addr_i ADDR_WIDTH                register to reserve
//   write_i        1                         write enable
//   waddr_i        ADDR_WIDTH                write address
//   wdata_i        DATA_WIDTH                write data
//   flush_i        1                         clear every busy bit at next edge
//   busy_count_o   ADDR_WIDTH+1              number of busy registers
interface regs_mp_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter int NB_READ_PORTS = 2
);
    logic [NB_READ_PORTS*ADDR_WIDTH-1:0] raddr_i;
    logic [NB_READ_PORTS*DATA_WIDTH-1:0] rdata_o;
    logic [NB_READ_PORTS-1:0]            rbusy_o;
    logic                                reserve_i;
    logic [ADDR_WIDTH-1:0]               reserve_addr_i;
    logic                                write_i;
    logic [ADDR_WIDTH-1:0]               waddr_i;
    logic [DATA_WIDTH-1:0]               wdata_i;
    logic                                flush_i;
    logic [ADDR_WIDTH:0]                 busy_count_o;

    modport master (
        output raddr_i, reserve_i, reserve_addr_i, write_i, waddr_i, wdata_i, flush_i,
        input  rdata_o, rbusy_o, busy_count_o
    );

    modport slave (
        input  raddr_i, reserve_i, reserve_addr_i, write_i, waddr_i, wdata_i, flush_i,
        output rdata_o, rbusy_o, busy_count_o
    );
endinterface

// File: rtl/regs_mp.sv
// regs_mp: multi-port register file with a pending-write (busy) scoreboard.
// Holds 2**ADDR_WIDTH words, NB_READ_PORTS combinational read ports, one
// synchronous write port, and a busy bit per register plus a registered count
// of busy registers.
// Ports:
//   clk_i  sole clock, rising edge
//   rst_i  synchronous active-low reset
//   bus    regs_mp_if.slave (reads, reserve, write, flush, busy count)
// Build option:
//   REGS_BYPASS_EN  when defined, a write forwards to any read port addressing
//                   the same register in the same cycle.
module regs_mp #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter int NB_READ_PORTS = 2,
    parameter bit ZERO_REG      = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    regs_mp_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_next;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;

    logic wr_en;
    logic rs_en;
    logic cnt_inc;
    logic cnt_dec;

    // Register 0 is hardwired when ZERO_REG is set, so drop its write/reserve here.
    assign wr_en = bus.write_i   && !(ZERO_REG && (bus.waddr_i == '0));
    assign rs_en = bus.reserve_i && !(ZERO_REG && (bus.reserve_addr_i == '0));

    always_comb begin
        busy_next = busy;
        if (wr_en) busy_next[bus.waddr_i] = 1'b0;
        if (rs_en) busy_next[bus.reserve_addr_i] = 1'b1;
    end

    // A write only decrements if its bit actually ends up cleared, i.e. it was
    // busy and no reservation re-sets it in the same edge.
    assign cnt_inc = rs_en && !busy[bus.reserve_addr_i];
    assign cnt_dec = wr_en && busy[bus.waddr_i]
                     && !(rs_en && (bus.reserve_addr_i == bus.waddr_i));
    assign count_next = count + CW'(cnt_inc) - CW'(cnt_dec);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy  <= '0;
            count <= '0;
        end else begin
            if (wr_en) mem[bus.waddr_i] <= bus.wdata_i;
            if (bus.flush_i) begin
                busy  <= '0;
                count <= '0;
            end else begin
                busy  <= busy_next;
                count <= count_next;
            end
        end
    end

    assign bus.busy_count_o = count;

    logic [DATA_WIDTH-1:0] rd [NB_READ_PORTS];
    logic                  rb [NB_READ_PORTS];

    for (genvar k = 0; k < NB_READ_PORTS; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        assign ra = bus.raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rd[k] = mem[ra];
            rb[k] = busy[ra];
            if (ZERO_REG && (ra == '0)) begin
                rd[k] = '0;
                rb[k] = 1'b0;
            end
`ifdef REGS_BYPASS_EN
            else if (bus.write_i && (ra == bus.waddr_i)) begin
                // A same-cycle reserve of this register wins over the write's clear.
                rd[k] = bus.wdata_i;
                rb[k] = bus.reserve_i && (bus.reserve_addr_i == ra);
            end
`endif
        end

        assign bus.rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = rd[k];
        assign bus.rbusy_o[k] = rb[k];
    end
endmodule

// File: tb/tb_regs_mp.sv
module tb_regs_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NP = 2;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b0;

    regs_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NB_READ_PORTS(NP)) bus ();

    regs_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NB_READ_PORTS(NP), .ZERO_REG(1'b1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: plain arrays of register contents and pending flags.
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];
    bit            bypass_on;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int busy_total();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic int port_addr(input int k);
        return int'(bus.raddr_i[k*AW +: AW]);
    endfunction

    task automatic set_port(input int k, input int a);
        bus.raddr_i[k*AW +: AW] = AW'(a);
    endtask

    task automatic idle();
        bus.reserve_i = 1'b0;
        bus.reserve_addr_i = '0;
        bus.write_i = 1'b0;
        bus.waddr_i = '0;
        bus.wdata_i = '0;
        bus.flush_i = 1'b0;
        rst = 1'b1;
    endtask

    // Check every read port and the count against the model, before the edge.
    task automatic settle();
        int a;
        logic [DW-1:0] ed;
        bit eb;
        #1;
        for (int k = 0; k < NP; k++) begin
            a = port_addr(k);
            ed = m_mem[a];
            eb = m_busy[a];
            if (a == 0) begin
                ed = '0;
                eb = 1'b0;
            end else if (bypass_on && bus.write_i && a == int'(bus.waddr_i)) begin
                ed = bus.wdata_i;
                eb = bus.reserve_i && a == int'(bus.reserve_addr_i);
            end
            chk($sformatf("rdata[%0d]@r%0d", k, a), 64'(bus.rdata_o[k*DW +: DW]), 64'(ed));
            chk($sformatf("rbusy[%0d]@r%0d", k, a), 64'(bus.rbusy_o[k]), 64'(eb));
        end
        chk("busy_count", 64'(bus.busy_count_o), 64'(busy_total()));
    endtask

    // Take the edge and apply the register-file rules to the model.
    task automatic edge_step();
        int wa, ra;
        @(posedge clk);
        wa = int'(bus.waddr_i);
        ra = int'(bus.reserve_addr_i);
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (bus.write_i && wa != 0) m_mem[wa] = bus.wdata_i;
            if (bus.flush_i) begin
                for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
            end else begin
                if (bus.write_i && wa != 0) m_busy[wa] = 1'b0;
                if (bus.reserve_i && ra != 0) m_busy[ra] = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        edge_step();
    endtask

    initial begin
`ifdef REGS_BYPASS_EN
        bypass_on = 1'b1;
`else
        bypass_on = 1'b0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_busy[i] = 1'b0;
        end
        bus.raddr_i = '0;
        idle();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Preload r5, then reset mid-life and check a clean file.
        idle();
        bus.write_i = 1'b1; bus.waddr_i = 5'd5; bus.wdata_i = 32'hDEADBEEF;
        bus.reserve_i = 1'b1; bus.reserve_addr_i = 5'd6;
        set_port(0, 5); set_port(1, 6);
        step();
        idle();
        settle();
        chk("preload_r5", 64'(bus.rdata_o[0 +: DW]), 64'h0DEADBEEF);
        chk("preload_cnt", 64'(bus.busy_count_o), 64'd1);
        rst = 1'b0;
        bus.write_i = 1'b1; bus.waddr_i = 5'd8; bus.wdata_i = 32'h1;
        edge_step();
        idle();
        settle();
        chk("reset_r5", 64'(bus.rdata_o[0 +: DW]), 64'd0);
        chk("reset_busy6", 64'(bus.rbusy_o[1]), 64'd0);
        chk("reset_cnt", 64'(bus.busy_count_o), 64'd0);
        edge_step();

        // Write r3, read on every port; write r0 is ignored.
        bus.write_i = 1'b1; bus.waddr_i = 5'd3; bus.wdata_i = 32'h12345678;
        for (int k = 0; k < NP; k++) set_port(k, 3);
        step();
        idle();
        settle();
        for (int k = 0; k < NP; k++)
            chk("r3_all_ports", 64'(bus.rdata_o[k*DW +: DW]), 64'h12345678);
        edge_step();
        bus.write_i = 1'b1; bus.waddr_i = 5'd0; bus.wdata_i = 32'hFFFFFFFF;
        set_port(0, 0);
        step();
        idle();
        settle();
        chk("r0_zero", 64'(bus.rdata_o[0 +: DW]), 64'd0);
        edge_step();

        // Reserve r7, then write it.
        bus.reserve_i = 1'b1; bus.reserve_addr_i = 5'd7;
        set_port(1, 7);
        step();
        idle();
        settle();
        chk("r7_busy", 64'(bus.rbusy_o[1]), 64'd1);
        chk("r7_cnt", 64'(bus.busy_count_o), 64'd1);
        bus.write_i = 1'b1; bus.waddr_i = 5'd7; bus.wdata_i = 32'hA5;
        edge_step();
        idle();
        settle();
        chk("r7_clear", 64'(bus.rbusy_o[1]), 64'd0);
        chk("r7_cnt0", 64'(bus.busy_count_o), 64'd0);
        chk("r7_data", 64'(bus.rdata_o[DW +: DW]), 64'hA5);
        edge_step();

        // Reserve and write r9 together; then flush against a reserve of r10.
        bus.reserve_i = 1'b1; bus.reserve_addr_i = 5'd9;
        bus.write_i = 1'b1; bus.waddr_i = 5'd9; bus.wdata_i = 32'h99;
        set_port(0, 9); set_port(1, 10);
        step();
        idle();
        settle();
        chk("r9_data", 64'(bus.rdata_o[0 +: DW]), 64'h99);
        chk("r9_busy", 64'(bus.rbusy_o[0]), 64'd1);
        chk("r9_cnt", 64'(bus.busy_count_o), 64'd1);
        bus.flush_i = 1'b1; bus.reserve_i = 1'b1; bus.reserve_addr_i = 5'd10;
        edge_step();
        idle();
        settle();
        chk("flush_r9", 64'(bus.rbusy_o[0]), 64'd0);
        chk("flush_r10", 64'(bus.rbusy_o[1]), 64'd0);
        chk("flush_cnt", 64'(bus.busy_count_o), 64'd0);
        edge_step();

        // r4 busy, then write r4 while port 1 reads it.
        bus.reserve_i = 1'b1; bus.reserve_addr_i = 5'd4;
        set_port(1, 4);
        step();
        idle();
        bus.write_i = 1'b1; bus.waddr_i = 5'd4; bus.wdata_i = 32'h55;
        settle();
        if (bypass_on) begin
            chk("bypass_data", 64'(bus.rdata_o[DW +: DW]), 64'h55);
            chk("bypass_busy", 64'(bus.rbusy_o[1]), 64'd0);
        end else begin
            chk("nobypass_data", 64'(bus.rdata_o[DW +: DW]), 64'd0);
            chk("nobypass_busy", 64'(bus.rbusy_o[1]), 64'd1);
        end
        edge_step();
        idle();

        // Saturation: reserve r1..r31, re-reserve r1, flush.
        for (int r = 1; r < DEPTH; r++) begin
            bus.reserve_i = 1'b1; bus.reserve_addr_i = AW'(r);
            step();
        end
        idle();
        settle();
        chk("sat_cnt", 64'(bus.busy_count_o), 64'd31);
        bus.reserve_i = 1'b1; bus.reserve_addr_i = 5'd1;
        edge_step();
        idle();
        settle();
        chk("sat_rereserve", 64'(bus.busy_count_o), 64'd31);
        bus.flush_i = 1'b1;
        edge_step();
        idle();
        settle();
        chk("sat_flush", 64'(bus.busy_count_o), 64'd0);
        edge_step();

        // Randomized traffic, including occasional flush and mid-sequence reset.
        for (int n = 0; n < 600; n++) begin
            bus.reserve_i      = ($urandom_range(0, 2) != 0);
            bus.reserve_addr_i = AW'($urandom_range(0, DEPTH - 1));
            bus.write_i        = ($urandom_range(0, 1) != 0);
            // Bias writes toward reserved registers so the count goes both ways.
            bus.waddr_i        = ($urandom_range(0, 3) == 0) ? bus.reserve_addr_i
                                                              : AW'($urandom_range(0, DEPTH - 1));
            bus.wdata_i        = $urandom;
            bus.flush_i        = ($urandom_range(0, 31) == 0);
            rst                = ($urandom_range(0, 79) != 0);
            for (int k = 0; k < NP; k++)
                set_port(k, ($urandom_range(0, 2) == 0) ? int'(bus.waddr_i)
                                                        : $urandom_range(0, DEPTH - 1));
            step();
        end
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
